// File: rtl/aes_mixcol_seq_if.sv
// Handshake bundle for the masked MixColumns sequencer.
// The master side feeds shared columns and consumes results; the slave side is the sequencer.
interface aes_mixcol_seq_if #(
  parameter int NSHARES = 2
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [32*NSHARES-1:0]  in_col;
  logic                   in_inv;
  logic                   out_valid;
  logic                   out_ready;
  logic [32*NSHARES-1:0]  out_col;
  logic                   busy;

  modport master (
    output in_valid, in_col, in_inv, out_ready,
    input  in_ready, out_valid, out_col, busy
  );

  modport slave (
    input  in_valid, in_col, in_inv, out_ready,
    output in_ready, out_valid, out_col, busy
  );

endinterface

// File: rtl/aes_mixcol_seq.sv
// Sequencer for the masked MixColumns step of a first-order TSM AES core.
// One output byte per share is produced per cycle over four CALC cycles.
// Each share has its own datapath, so shares never mix.
// Optional feature macro: AES_MIXCOL_INV_EN adds InvMixColumns selected by in_inv.
// With the macro undefined only forward MixColumns is built.

// GF(2^8) multiply-by-two (xtime), reduction polynomial x^8+x^4+x^3+x+1.
module aes_mul2 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule

module aes_mixcol_seq #(
  parameter int NSHARES = 2
) (
  input  logic             clk,
  input  logic             rst,
  aes_mixcol_seq_if.slave  bus
);

  localparam int W = 32 * NSHARES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [W-1:0]   col_q, col_d;
  logic [W-1:0]   res_q, res_d;
  logic           capture;
  logic [1:0]     k1, k2, k3;
  logic [7:0]     lane_b [NSHARES];

`ifdef AES_MIXCOL_INV_EN
  logic           inv_q, inv_d;
`else
  logic           unused_in_inv;
  assign unused_in_inv = bus.in_inv;
`endif

  assign capture = (state_q == IDLE) && bus.in_valid;

  // Neighbouring byte indices relative to the byte being produced; 2-bit wrap gives mod 4.
  assign k1 = cnt_q + 2'd1;
  assign k2 = cnt_q + 2'd2;
  assign k3 = cnt_q + 2'd3;

  function automatic logic [7:0] pick(input logic [31:0] c, input logic [1:0] k);
    logic [7:0] r;
    case (k)
      2'd0:    r = c[31:24];
      2'd1:    r = c[23:16];
      2'd2:    r = c[15:8];
      default: r = c[7:0];
    endcase
    return r;
  endfunction

  // Per-share byte lane. Linearity lets one xtime serve both 2*x0 and 3*x1:
  // 2*x0 ^ 3*x1 = 2*(x0 ^ x1) ^ x1. The inverse uses Horner form over a 3-deep xtime chain,
  // whose last stage doubles as the forward lane when the chain head is masked off.
  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    logic [31:0] a;
    logic [7:0]  x0, x1, x2, x3;
    logic [7:0]  m3_in, m3;

    assign a  = col_q[32*s +: 32];
    assign x0 = pick(a, cnt_q);
    assign x1 = pick(a, k1);
    assign x2 = pick(a, k2);
    assign x3 = pick(a, k3);

`ifdef AES_MIXCOL_INV_EN
    logic [7:0] m1_in, m1, m2_in, m2;

    assign m1_in = x0 ^ x1 ^ x2 ^ x3;
    aes_mul2 u_mul2_a (.a(m1_in), .y(m1));
    assign m2_in = m1 ^ x0 ^ x2;
    aes_mul2 u_mul2_b (.a(m2_in), .y(m2));
    assign m3_in = (inv_q ? m2 : 8'h00) ^ x0 ^ x1;
`else
    assign m3_in = x0 ^ x1;
`endif
    aes_mul2 u_mul2_c (.a(m3_in), .y(m3));

    assign lane_b[s] = m3 ^ x1 ^ x2 ^ x3;
  end

  // FSM state register with synchronous abort on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept in IDLE, four byte cycles in CALC, hold in DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)   state_d = CALC;
      CALC:    if (cnt_q == 2'd3)  state_d = DONE;
      DONE:    if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE so accept and emit never overlap.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      CALC:    bus.busy      = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Datapath next values: capture the column, step the byte counter, write one byte per share.
  always_comb begin
    col_d = col_q;
    cnt_d = cnt_q;
    res_d = res_q;
`ifdef AES_MIXCOL_INV_EN
    inv_d = inv_q;
`endif
    if (capture) begin
      col_d = bus.in_col;
      cnt_d = 2'd0;
`ifdef AES_MIXCOL_INV_EN
      inv_d = bus.in_inv;
`endif
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 2'd1;
      for (int s = 0; s < NSHARES; s++) begin
        res_d[32*s + 8*(3 - int'(cnt_q)) +: 8] = lane_b[s];
      end
    end
  end

  // Datapath registers; reset discards any column in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      cnt_q <= 2'd0;
      res_q <= '0;
`ifdef AES_MIXCOL_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      col_q <= col_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
`ifdef AES_MIXCOL_INV_EN
      inv_q <= inv_d;
`endif
    end
  end

  assign bus.out_col = res_q;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Self-checking bench for aes_mixcol_seq (two shares).
// The reference model is a generic GF(2^8) matrix-vector product applied to each share separately.
module tb_aes_mixcol_seq;

  localparam int NSH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_mixcol_seq_if #(.NSHARES(NSH)) bus_if ();

  aes_mixcol_seq #(.NSHARES(NSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Generic GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = x; bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix times column, byte a0 in the top bits.
  function automatic logic [31:0] mixColRef(input logic [31:0] c, input bit inv);
    logic [7:0]  a    [4];
    logic [7:0]  coef [4];
    logic [7:0]  b;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) a[k] = c[31-8*k -: 8];
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gmul(coef[j], a[(i+j)%4]);
      r[31-8*i -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [63:0] expCol(input logic [63:0] c, input bit inv);
    return {mixColRef(c[63:32], inv), mixColRef(c[31:0], inv)};
  endfunction

  function automatic bit effInv(input bit inv);
`ifdef AES_MIXCOL_INV_EN
    return inv;
`else
    return 1'b0 & inv;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one column for a single capture edge, then withdraw it.
  task automatic applyStimulus(input logic [63:0] col, input bit inv);
    checkOutput("pre_capture_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_col   = col;
    bus_if.in_inv   = inv;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.in_inv   = 1'b0;
    checkOutput("post_capture_busy", {63'd0, bus_if.busy}, 64'd1);
  endtask

  // Edge index (relative to capture edge) at which out_valid is first sampled high.
  task automatic waitValid(output int e);
    e = 1;
    while (!bus_if.out_valid && e < 30) begin
      tick();
      e++;
    end
  endtask

  task automatic runColumn(input string tag, input logic [63:0] col, input bit inv,
                           output logic [63:0] got);
    int e;
    applyStimulus(col, inv);
    waitValid(e);
    checkOutput({tag, "_latency"}, 64'(e), 64'd5);
    got = bus_if.out_col;
    checkOutput({tag, "_col"}, got, expCol(col, effInv(inv)));
    checkOutput({tag, "_no_accept_while_valid"}, {63'd0, bus_if.in_ready}, 64'd0);
    tick();
    checkOutput({tag, "_in_ready_after"}, {63'd0, bus_if.in_ready}, 64'd1);
    checkOutput({tag, "_out_valid_after"}, {63'd0, bus_if.out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] got, col, held;
    logic [31:0] plain, m;
    logic [63:0] cols [4];
    int          acc_cyc [4];
    int          nacc, cyc, e;
    bit          accepted;
    logic [63:0] results [$];

    bus_if.in_valid  = 1'b0;
    bus_if.in_col    = '0;
    bus_if.in_inv    = 1'b0;
    bus_if.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_in_ready",  {63'd0, bus_if.in_ready},  64'd1);
    checkOutput("reset_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    checkOutput("reset_busy",      {63'd0, bus_if.busy},      64'd0);
    checkOutput("reset_out_col",   bus_if.out_col,            64'd0);

    // Unmasked known vector
    runColumn("unmasked", {32'h0, 32'hdb135345}, 1'b0, got);
    checkOutput("unmasked_xor", {32'h0, got[63:32] ^ got[31:0]}, {32'h0, 32'h8e4da1bc});

    // Masked known vector; share1 sits in the upper half
    runColumn("masked", {32'hdb135345 ^ 32'ha5a5a5a5, 32'ha5a5a5a5}, 1'b0, got);
    checkOutput("masked_xor",    {32'h0, got[63:32] ^ got[31:0]}, {32'h0, 32'h8e4da1bc});
    checkOutput("masked_share0", {32'h0, got[31:0]},               {32'h0, 32'ha5a5a5a5});

    // Random masked columns
    for (int i = 0; i < 6; i++) begin
      plain = $urandom;
      m     = $urandom;
      runColumn("random", {plain ^ m, m}, 1'b0, got);
      checkOutput("random_xor", {32'h0, got[63:32] ^ got[31:0]}, {32'h0, mixColRef(plain, 1'b0)});
    end

    // Backpressure: result held, in_valid pulses ignored
    bus_if.out_ready = 1'b0;
    applyStimulus({32'h0, 32'hf20a225c}, 1'b0);
    waitValid(e);
    checkOutput("bp_latency", 64'(e), 64'd5);
    held = bus_if.out_col;
    checkOutput("bp_col", held, {32'h0, 32'h9fdc589d});
    for (int i = 0; i < 10; i++) begin
      bus_if.in_valid = i[0];
      bus_if.in_col   = {$urandom, $urandom};
      tick();
      checkOutput("bp_hold_col",   bus_if.out_col,            {32'h0, 32'h9fdc589d});
      checkOutput("bp_hold_valid", {63'd0, bus_if.out_valid}, 64'd1);
      checkOutput("bp_hold_ready", {63'd0, bus_if.in_ready},  64'd0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    checkOutput("bp_release_in_ready",  {63'd0, bus_if.in_ready},  64'd1);
    checkOutput("bp_release_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    checkOutput("bp_release_busy",      {63'd0, bus_if.busy},      64'd0);

    // Reset while cnt==2
    applyStimulus({$urandom, $urandom}, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    checkOutput("abort_in_ready",  {63'd0, bus_if.in_ready},  64'd1);
    checkOutput("abort_out_col",   bus_if.out_col,            64'd0);
    checkOutput("abort_busy",      {63'd0, bus_if.busy},      64'd0);
    rst = 1'b0;
    tick(); tick();
    checkOutput("abort_no_partial", {63'd0, bus_if.out_valid}, 64'd0);
    runColumn("after_abort", {32'h0, 32'h01010101}, 1'b0, got);
    checkOutput("after_abort_xor", {32'h0, got[63:32] ^ got[31:0]}, {32'h0, 32'h01010101});

    // Back-to-back with in_valid held
    for (int i = 0; i < 4; i++) begin
      m = $urandom;
      cols[i] = {m ^ $urandom, m};
    end
    nacc = 0; cyc = 0;
    bus_if.in_col   = cols[0];
    bus_if.in_valid = 1'b1;
    while ((nacc < 4 || results.size() < 4) && cyc < 200) begin
      accepted = bus_if.in_valid && bus_if.in_ready;
      if (accepted) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (bus_if.out_valid && bus_if.out_ready) results.push_back(bus_if.out_col);
      tick();
      cyc++;
      if (accepted) begin
        if (nacc < 4) bus_if.in_col = cols[nacc];
        else          bus_if.in_valid = 1'b0;
      end
    end
    bus_if.in_valid = 1'b0;
    checkOutput("b2b_accepted", 64'(nacc), 64'd4);
    checkOutput("b2b_results",  64'(results.size()), 64'd4);
    for (int i = 1; i < nacc && i < 4; i++)
      checkOutput("b2b_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd6);
    for (int i = 0; i < results.size() && i < 4; i++)
      checkOutput("b2b_order", results[i], expCol(cols[i], 1'b0));
    tick();

    // Inverse select: honoured with the feature, ignored without it
    col = {32'h8e4da1bc ^ 32'ha5a5a5a5, 32'ha5a5a5a5};
    runColumn("inv_sel", col, 1'b1, got);
`ifdef AES_MIXCOL_INV_EN
    checkOutput("inv_xor", {32'h0, got[63:32] ^ got[31:0]}, {32'h0, 32'hdb135345});
`else
    checkOutput("inv_ignored_xor", {32'h0, got[63:32] ^ got[31:0]}, {32'h0, mixColRef(32'h8e4da1bc, 1'b0)});
`endif
    runColumn("fwd_after_inv", {32'h0, 32'hdb135345}, 1'b0, got);
    checkOutput("fwd_after_inv_xor", {32'h0, got[63:32] ^ got[31:0]}, {32'h0, 32'h8e4da1bc});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
